// File: rtl/perf_window_ctrl_if.sv
// rtl/perf_window_ctrl_if.sv - report beat stream between perf_window_ctrl and its consumer
interface perf_window_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic             rpt_valid;
  logic             rpt_ready;
  logic [CH_W-1:0]  rpt_ch;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_sat;

  modport master (output rpt_valid, rpt_ch, rpt_count, rpt_sat, input rpt_ready);
  modport slave  (input rpt_valid, rpt_ch, rpt_count, rpt_sat, output rpt_ready);
endinterface

// File: rtl/perf_window_ctrl.sv
// rtl/perf_window_ctrl.sv - windowed per-channel handshake counter with serial report
// Optional: PERF_WINDOW_AUTO_RESTART_EN rearms the window after the last report beat.
module perf_window_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WIN_W-1:0]     window_len,
  input  logic [NUM_CH-1:0]    ev_valid,
  input  logic [NUM_CH-1:0]    ev_ready,
  output logic                 busy,
  perf_window_ctrl_if.master   rpt
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   remain_q;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [NUM_CH-1:0]  sat_q;
  logic [CH_W-1:0]    beat_q;
  logic               busy_q, busy_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic               beat_acc, last_acc, window_done, restart, load_window;
  logic [WIN_W-1:0]   start_len, reload_len;

  // A zero-length window still gets one RUN cycle.
  assign start_len   = (window_len == '0) ? WIN_W'(1) : window_len;
  assign beat_acc    = (state_q == REPORT) && rpt.rpt_ready;
  assign last_acc    = beat_acc && (beat_q == LAST_CH);
  assign window_done = (state_q == RUN) && (stop || (remain_q == WIN_W'(1)));

`ifdef PERF_WINDOW_AUTO_RESTART_EN
  logic [WIN_W-1:0] len_q;
  logic             cancel_q;

  assign restart    = last_acc && !(cancel_q || stop);
  assign reload_len = restart ? len_q : start_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start)
        len_q <= start_len;
      if (last_acc)
        cancel_q <= 1'b0;
      else if ((state_q == REPORT) && stop)
        cancel_q <= 1'b1;
    end
  end
`else
  assign restart    = 1'b0;
  assign reload_len = start_len;
`endif

  assign load_window = ((state_q == IDLE) && start) || restart;

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (window_done) state_d = REPORT;
      REPORT:  if (last_acc) state_d = restart ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d != IDLE);
    rpt_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      rpt_valid_q <= 1'b0;
      remain_q    <= '0;
      sat_q       <= '0;
      beat_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      busy_q      <= busy_d;
      rpt_valid_q <= rpt_valid_d;
      if (load_window) begin
        remain_q <= reload_len;
        sat_q    <= '0;
        for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else if (state_q == RUN) begin
        remain_q <= remain_q - WIN_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
          if (ev_valid[i] && ev_ready[i]) begin
            if (cnt_q[i] == CNT_MAX) sat_q[i] <= 1'b1;
            else                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
      if (beat_acc)
        beat_q <= last_acc ? '0 : beat_q + CH_W'(1);
    end
  end

  assign busy          = busy_q;
  assign rpt.rpt_valid = rpt_valid_q;
  assign rpt.rpt_ch    = beat_q;
  assign rpt.rpt_count = cnt_q[beat_q];
  assign rpt.rpt_sat   = sat_q[beat_q];
endmodule
